// File: rtl/game_pkg.sv
// Shared scan-code constants and keyboard decoder state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_ERR0  = 8'h00;
    localparam logic [7:0] SC_ERR1  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } kbd_st_t;

endpackage

// File: rtl/game_key_decoder.sv
// PS/2 set-2 byte stream -> held levels for left/right/space plus space press and protocol error pulses.
// Latency: 1 cycle from the final byte of a sequence to registered outputs.
// Backpressure: none; every keyValid byte is consumed. Option GAME_KEYS_LAST_WINS_EN: most recent arrow wins.
module game_key_decoder #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] keyCode,
    input  logic       keyValid,
    output logic       rightArrow,
    output logic       leftArrow,
    output logic       spaceBar,
    output logic       spacePress,
    output logic       protoErr
);
    import game_pkg::*;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    kbd_st_t       st, st_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          mk, bk, ext, ovr, err_nxt;
    logic          left_q, right_q;
    logic          left_nxt, right_nxt, space_nxt;

    // Decoder state and prefix timeout counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st  <= IDLE;
            cnt <= '0;
        end else begin
            st  <= st_nxt;
            cnt <= cnt_nxt;
        end
    end

    // Next state plus one-cycle decode events (make/break, extended, overrun, error).
    always_comb begin
        st_nxt  = st;
        err_nxt = 1'b0;
        mk      = 1'b0;
        bk      = 1'b0;
        ext     = 1'b0;
        ovr     = 1'b0;
        if (keyValid) begin
            case (st)
                IDLE: begin
                    if (keyCode == SC_EXT)
                        st_nxt = EXT;
                    else if (keyCode == SC_BRK)
                        st_nxt = BRK;
                    else if (keyCode == SC_ERR0 || keyCode == SC_ERR1) begin
                        ovr     = 1'b1;
                        err_nxt = 1'b1;
                    end else
                        mk = 1'b1;
                end
                EXT: begin
                    if (keyCode == SC_BRK)
                        st_nxt = EXT_BRK;
                    else if (keyCode == SC_EXT)
                        err_nxt = 1'b1;
                    else begin
                        mk     = 1'b1;
                        ext    = 1'b1;
                        st_nxt = IDLE;
                    end
                end
                BRK: begin
                    st_nxt = IDLE;
                    if (keyCode == SC_EXT || keyCode == SC_BRK)
                        err_nxt = 1'b1;
                    else
                        bk = 1'b1;
                end
                EXT_BRK: begin
                    st_nxt = IDLE;
                    if (keyCode == SC_EXT || keyCode == SC_BRK)
                        err_nxt = 1'b1;
                    else begin
                        bk  = 1'b1;
                        ext = 1'b1;
                    end
                end
                default: st_nxt = IDLE;
            endcase
        end else if (st != IDLE && cnt == CNT_MAX) begin
            // A byte arriving in the expiry cycle takes the branch above instead.
            st_nxt  = IDLE;
            err_nxt = 1'b1;
        end
    end

    // Counter restarts on every byte, idles at zero, saturates rather than wraps.
    always_comb begin
        if (keyValid || st_nxt == IDLE)
            cnt_nxt = '0;
        else if (cnt == CNT_MAX)
            cnt_nxt = cnt;
        else
            cnt_nxt = cnt + 1'b1;
    end

    // Held-flag update; repeats of a held key rewrite the same value, breaks of unheld keys are no-ops.
    always_comb begin
        space_nxt = spaceBar;
        left_nxt  = left_q;
        right_nxt = right_q;
        if (ovr) begin
            space_nxt = 1'b0;
            left_nxt  = 1'b0;
            right_nxt = 1'b0;
        end else if (mk || bk) begin
            if (!ext && keyCode == SC_SPACE) space_nxt = mk;
            if (ext && keyCode == SC_LEFT)   left_nxt  = mk;
            if (ext && keyCode == SC_RIGHT)  right_nxt = mk;
        end
    end

    // Held flags and pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            spaceBar   <= 1'b0;
            spacePress <= 1'b0;
            protoErr   <= 1'b0;
        end else begin
            left_q     <= left_nxt;
            right_q    <= right_nxt;
            spaceBar   <= space_nxt;
            spacePress <= space_nxt & ~spaceBar;
            protoErr   <= err_nxt;
        end
    end

`ifdef GAME_KEYS_LAST_WINS_EN
    logic last_right, last_right_nxt;

    // Only a fresh press (not-held -> held) moves the most-recent marker.
    always_comb begin
        last_right_nxt = last_right;
        if (left_nxt && !left_q)
            last_right_nxt = 1'b0;
        else if (right_nxt && !right_q)
            last_right_nxt = 1'b1;
    end

    // Arrow outputs arbitrated by the most recently pressed arrow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_right <= 1'b1;
            rightArrow <= 1'b0;
            leftArrow  <= 1'b0;
        end else begin
            last_right <= last_right_nxt;
            rightArrow <= right_nxt & (~left_nxt  |  last_right_nxt);
            leftArrow  <= left_nxt  & (~right_nxt | ~last_right_nxt);
        end
    end
`else
    assign rightArrow = right_q;
    assign leftArrow  = left_q;
`endif

endmodule

// File: doc/game_key_decoder.md
# game_key_decoder

Converts the raw PS/2 set-2 scan-code byte stream from the keyboard receiver into the held-key levels and press pulses consumed by the game state machine. It tracks left arrow, right arrow and space bar. It strips typematic repeats and handles the `E0` extended prefix and the `F0` break prefix. It sits between the keyboard byte receiver and the game state machine, one clock domain, no back-pressure.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle cycles allowed between a prefix byte and its following byte. This is 20 ms at 50 MHz.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `keyCode` in 8: received scan-code byte; valid only while `keyValid` is high.
- `keyValid` in 1: single-cycle strobe, one per received byte, with at most one byte per cycle.
- `rightArrow` out 1: right arrow held (level).
- `leftArrow` out 1: left arrow held (level).
- `spaceBar` out 1: space held (level).
- `spacePress` out 1: one-cycle pulse on a space not-held→held transition.
- `protoErr` out 1: one-cycle pulse on a prefix timeout or an illegal prefix sequence.

## Operation
- Decoder states: `IDLE`, `EXT` (after `E0`), `BRK` (after `F0`), `EXT_BRK` (after `E0 F0`).
- Transitions, taken only on `keyValid`:
  - `IDLE`: `E0`→`EXT`, `F0`→`BRK`, any other code is a make code and returns to `IDLE`.
  - `EXT`: `F0`→`EXT_BRK`, `E0`→`EXT` and pulses `protoErr`, any other code is an extended make and returns to `IDLE`.
  - `BRK`: any code is a break and returns to `IDLE`, except `E0`/`F0`, which pulse `protoErr` and return to `IDLE`.
  - `EXT_BRK`: any code is an extended break and returns to `IDLE`, except `E0`/`F0`, which pulse `protoErr` and return to `IDLE`.
- Recognised codes:
  - Space `29`, non-extended only.
  - Left arrow `E0 6B`, extended only.
  - Right arrow `E0 74`, extended only.
  - Non-extended `6B`/`74` (keypad 4/6) and extended `29` are ignored.
- All other codes are ignored and cause no state change in the held flags.
- Make sets the held flag; break clears it.
- Typematic repeats are repeated makes of an already-held key. They leave the held flag unchanged and produce no `spacePress`.
- Overrun/error byte `00` or `FF` in `IDLE`:
  - clears all held flags;
  - pulses `protoErr`;
  - produces no `spacePress`.
- Timeout: a counter runs in any non-`IDLE` state and restarts on every `keyValid`. When it reaches `TIMEOUT_CYCLES-1`, the decoder returns to `IDLE`, pulses `protoErr`, and leaves the held flags unchanged.
- Counter width is `$clog2(TIMEOUT_CYCLES)`. The counter saturates and does not wrap.
- A break for a key that is not held is a no-op with no error.

## Timing
- All outputs are registered.
- A level or pulse changes on the first `clk` edge after the edge that samples the final byte of a sequence (`keyValid` high). Latency is therefore 1 cycle from the final byte.
- `spacePress` is high for exactly one cycle and coincides with the first cycle `spaceBar` is high.
- Reset values: state `IDLE`, timeout counter 0, all five outputs 0.
- Reset asserted mid-sequence (for example after `E0`) discards the partial sequence. The next byte after reset is decoded from `IDLE`.
- If the timeout expiry and a `keyValid` occur in the same cycle, the byte wins: it is decoded normally and no `protoErr` is raised.

## Configuration
- `GAME_KEYS_LAST_WINS_EN` defined:
  - When both arrows are held, only the most recently pressed arrow is asserted.
  - Releasing that arrow re-asserts the other on the next cycle if it is still held.
  - A typematic repeat does not change which arrow was most recent.
  - This needs one extra register for the last-pressed arrow, reset to right.
- `GAME_KEYS_LAST_WINS_EN` undefined:
  - `rightArrow` and `leftArrow` directly reflect the two held flags, and both may be high together.

## Structure
- Shared package `game_pkg` holds:
  - scan-code constants `SC_EXT`=`E0`, `SC_BRK`=`F0`, `SC_SPACE`=`29`, `SC_LEFT`=`6B`, `SC_RIGHT`=`74`, `SC_ERR0`=`00`, `SC_ERR1`=`FF`;
  - the decoder state enum `kbd_st_t`.
- Single module, no sub-module. The timeout counter and the held-flag registers live inline.

## Test plan
- After reset, send `29` → `spaceBar`=1 and `spacePress`=1 for one cycle. Send `29 29 29` → `spaceBar` stays 1 with no further `spacePress`. Send `F0 29` → `spaceBar`=0.
- Send `E0 6B` → `leftArrow`=1. Send `6B` alone → no change. Send `E0 F0 6B` → `leftArrow`=0. Send `F0 6B` → no change, no error.
- Send `E0`, then idle `TIMEOUT_CYCLES` cycles → `protoErr` pulses once and state returns to `IDLE`. Then send `74` → `rightArrow` stays 0.
- Press right (`E0 74`), then left (`E0 6B`):
  - With `GAME_KEYS_LAST_WINS_EN` → left=1, right=0. Then release left (`E0 F0 6B`) → right=1.
  - Without the macro → both=1 after the two makes.
- Hold space and both arrows, then send `FF` → all levels 0, one `protoErr`, no `spacePress`.
- Assert `reset` between `E0` and `74` → all outputs 0. The following `74` is ignored, and `29` then sets `spaceBar`.
